vec_alu_sequencer: RTL and testbench

Element sequencer that feeds the vector integer ALU. It accepts one vector arithmetic instruction at a time and walks element indices 0..vl-1. For each element it reads both source elements and the v0 mask bit from the vector register file, presents them to the combinational element ALU, and writes the result back to vd. Masked-off elements are left undisturbed. The block sits between instruction dispatch and the VRF/ALU pair.

---
 rtl/vec_pkg.sv | 38 +++
 rtl/vec_seq_pipe.sv | 69 ++++++
 rtl/vec_alu_sequencer.sv | 137 +++++++++++++
 tb/tb_vec_alu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and sizing for the vector ALU element sequencer.
package vec_pkg;

  localparam int unsigned VLMAX = 16;
  localparam int unsigned ELEN  = 32;
  localparam int unsigned IDX_W = $clog2(VLMAX);
  localparam int unsigned VL_W  = $clog2(VLMAX + 1);
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 4;

  typedef enum logic [OP_W-1:0] {
    VOP_ADD = 4'd0,
    VOP_SUB = 4'd1,
    VOP_AND = 4'd2,
    VOP_OR  = 4'd3,
    VOP_XOR = 4'd4,
    VOP_SLL = 4'd5,
    VOP_SRL = 4'd6,
    VOP_SRA = 4'd7
  } vop_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2
  } seq_state_t;

  // Latched instruction fields; vl is already clamped to VLMAX.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] vd;
    logic [REG_W-1:0] vs1;
    logic [REG_W-1:0] vs2;
    logic [VL_W-1:0]  vl;
    logic             vm;
  } seq_instr_t;

endpackage

// File: rtl/vec_seq_pipe.sv
// Element pipeline: stage 1 presents VRF data to the ALU, stage 2 holds the writeback.
module vec_seq_pipe
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic             rd_last_i,
  input  logic             vm_i,
  input  logic             rd_mask_i,
  input  logic [ELEN-1:0]  rd_data1_i,
  input  logic [ELEN-1:0]  rd_data2_i,
  input  logic [ELEN-1:0]  alu_result_i,
  output logic [ELEN-1:0]  alu_op1_c,
  output logic [ELEN-1:0]  alu_op2_c,
  output logic             alu_mask_c,
  output logic             s1_last_c,
  output logic             wb_en_o,
  output logic [IDX_W-1:0] wb_idx_o,
  output logic [ELEN-1:0]  wb_data_o
);

  logic             s1_valid_q;
  logic             s1_last_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s2_wen_q;
  logic [IDX_W-1:0] s2_idx_q;
  logic [ELEN-1:0]  s2_data_q;

  // Read data arrives the cycle after rd_en; operands are zeroed when idle.
  assign alu_op1_c  = s1_valid_q ? rd_data2_i : '0;
  assign alu_op2_c  = s1_valid_q ? rd_data1_i : '0;
  assign alu_mask_c = s1_valid_q & (vm_i | rd_mask_i);
  assign s1_last_c  = s1_valid_q & s1_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= rd_en_i;
      s1_last_q  <= rd_en_i & rd_last_i;
      if (rd_en_i) begin
        s1_idx_q <= rd_idx_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_wen_q  <= 1'b0;
      s2_idx_q  <= '0;
      s2_data_q <= '0;
    end else begin
      s2_wen_q <= alu_mask_c;
      if (s1_valid_q) begin
        s2_idx_q  <= s1_idx_q;
        s2_data_q <= alu_result_i;
      end
    end
  end

  assign wb_en_o   = s2_wen_q;
  assign wb_idx_o  = s2_idx_q;
  assign wb_data_o = s2_data_q;

endmodule

// File: rtl/vec_alu_sequencer.sv
// Walks element indices of one vector ALU instruction: VRF read, ALU, writeback to vd.
module vec_alu_sequencer
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OP_W-1:0]  instr_op,
  input  logic [REG_W-1:0] instr_vd,
  input  logic [REG_W-1:0] instr_vs1,
  input  logic [REG_W-1:0] instr_vs2,
  input  logic [VL_W-1:0]  instr_vl,
  input  logic             instr_vm,
  output logic             rd_en,
  output logic [REG_W-1:0] rd_addr1,
  output logic [REG_W-1:0] rd_addr2,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [ELEN-1:0]  rd_data1,
  input  logic [ELEN-1:0]  rd_data2,
  input  logic             rd_mask,
  output logic [ELEN-1:0]  alu_op1,
  output logic [ELEN-1:0]  alu_op2,
  output logic [OP_W-1:0]  alu_operation,
  output logic             alu_mask,
  input  logic [ELEN-1:0]  alu_result,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_addr,
  output logic [IDX_W-1:0] wb_idx,
  output logic [ELEN-1:0]  wb_data,
  output logic             done
);

  seq_state_t       state_q, state_d;
  seq_instr_t       instr_q, instr_d;
  logic             rd_en_q, rd_en_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [VL_W-1:0]  vl_clamp_c;
  logic             issue_last_c;
  logic             s1_last_c;

  assign vl_clamp_c   = (instr_vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : instr_vl;
  assign issue_last_c = (VL_W'(rd_idx_q) == (instr_q.vl - VL_W'(1)));

  // Next-state: the read index doubles as the element counter.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    rd_en_d  = 1'b0;
    rd_idx_d = rd_idx_q;
    done_d   = s1_last_c;
    unique case (state_q)
      SEQ_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d.op  = instr_op;
          instr_d.vd  = instr_vd;
          instr_d.vs1 = instr_vs1;
          instr_d.vs2 = instr_vs2;
          instr_d.vl  = vl_clamp_c;
          instr_d.vm  = instr_vm;
          rd_idx_d    = '0;
          if (vl_clamp_c == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SEQ_RUN;
            rd_en_d = 1'b1;
          end
        end
      end
      SEQ_RUN: begin
        if (issue_last_c) begin
          state_d = SEQ_DRAIN;
        end else begin
          rd_en_d  = 1'b1;
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      SEQ_DRAIN: begin
        if (done_q) begin
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    ready_d = (state_d == SEQ_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEQ_IDLE;
      instr_q  <= '0;
      rd_en_q  <= 1'b0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      rd_en_q  <= rd_en_d;
      rd_idx_q <= rd_idx_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  vec_seq_pipe u_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en_i      (rd_en_q),
    .rd_idx_i     (rd_idx_q),
    .rd_last_i    (issue_last_c),
    .vm_i         (instr_q.vm),
    .rd_mask_i    (rd_mask),
    .rd_data1_i   (rd_data1),
    .rd_data2_i   (rd_data2),
    .alu_result_i (alu_result),
    .alu_op1_c    (alu_op1),
    .alu_op2_c    (alu_op2),
    .alu_mask_c   (alu_mask),
    .s1_last_c    (s1_last_c),
    .wb_en_o      (wb_en),
    .wb_idx_o     (wb_idx),
    .wb_data_o    (wb_data)
  );

  assign instr_ready   = ready_q;
  assign rd_en         = rd_en_q;
  assign rd_idx        = rd_idx_q;
  assign rd_addr1      = instr_q.vs1;
  assign rd_addr2      = instr_q.vs2;
  assign alu_operation = instr_q.op;
  assign wb_addr       = instr_q.vd;
  assign done          = done_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Randomized and directed bench for vec_alu_sequencer with a VRF/ALU model and per-cycle checks.
module tb_vec_alu_sequencer;
  import vec_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [OP_W-1:0]  instr_op;
  logic [REG_W-1:0] instr_vd, instr_vs1, instr_vs2;
  logic [VL_W-1:0]  instr_vl;
  logic             instr_vm;
  logic             rd_en;
  logic [REG_W-1:0] rd_addr1, rd_addr2;
  logic [IDX_W-1:0] rd_idx;
  logic [ELEN-1:0]  rd_data1, rd_data2;
  logic             rd_mask;
  logic [ELEN-1:0]  alu_op1, alu_op2;
  logic [OP_W-1:0]  alu_operation;
  logic             alu_mask;
  logic [ELEN-1:0]  alu_result;
  logic             wb_en;
  logic [REG_W-1:0] wb_addr;
  logic [IDX_W-1:0] wb_idx;
  logic [ELEN-1:0]  wb_data;
  logic             done;

  logic [ELEN-1:0]  vrf [32][VLMAX];
  logic [VLMAX-1:0] v0_bits = '0;
  logic             tb_we = 1'b0;
  logic [REG_W-1:0] tb_wa = '0;
  logic [IDX_W-1:0] tb_wi = '0;
  logic [ELEN-1:0]  tb_wd = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2),
    .instr_vl(instr_vl), .instr_vm(instr_vm),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_idx(rd_idx),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_mask(rd_mask),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation),
    .alu_mask(alu_mask), .alu_result(alu_result),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_idx(wb_idx), .wb_data(wb_data),
    .done(done)
  );

  // Element ALU behaviour: a is the vs2 element, b the vs1 element.
  function automatic logic [ELEN-1:0] alu_ref(input logic [OP_W-1:0] op,
                                               input logic [ELEN-1:0] a,
                                               input logic [ELEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return ELEN'($signed(a) >>> sh);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_operation, alu_op1, alu_op2);

  // VRF model: one-cycle read latency, writes land at the clock edge.
  initial begin
    for (int a = 0; a < 32; a++)
      for (int i = 0; i < int'(VLMAX); i++) vrf[a][i] = $urandom;
    rd_data1 = '0;
    rd_data2 = '0;
    rd_mask  = 1'b0;
    forever begin
      @(posedge clk);
      if (tb_we) vrf[tb_wa][tb_wi] <= tb_wd;
      if (wb_en) vrf[wb_addr][wb_idx] <= wb_data;
      rd_data1 <= vrf[rd_addr1][rd_idx];
      rd_data2 <= vrf[rd_addr2][rd_idx];
      rd_mask  <= v0_bits[rd_idx];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [REG_W-1:0] a, input int i, input logic [ELEN-1:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wi = IDX_W'(i);
    tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Offer an instruction and return just after the accepting edge.
  task automatic issue(input logic [OP_W-1:0] op, input logic [REG_W-1:0] vd,
                       input logic [REG_W-1:0] vs1, input logic [REG_W-1:0] vs2,
                       input int vl, input logic vm);
    bit ok;
    @(negedge clk);
    instr_op = op; instr_vd = vd; instr_vs1 = vs1; instr_vs2 = vs2;
    instr_vl = VL_W'(vl); instr_vm = vm; instr_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 64; w++) begin
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // Cycle-by-cycle expectations from the accept edge, then the final vd contents.
  task automatic check_instr(input logic [OP_W-1:0] op, input logic [REG_W-1:0] vd,
                             input logic [REG_W-1:0] vs1, input logic [REG_W-1:0] vs2,
                             input int vl, input logic vm, input bit hold, input bit noise);
    int vle;
    int k;
    logic [ELEN-1:0]  s1[VLMAX];
    logic [ELEN-1:0]  s2[VLMAX];
    logic [ELEN-1:0]  old[VLMAX];
    logic [VLMAX-1:0] msk;
    logic exp_rd, exp_wb, exp_done, exp_rdy;
    logic [ELEN-1:0] exp_v;
    vle = (vl > int'(VLMAX)) ? int'(VLMAX) : vl;
    #1;
    msk = v0_bits;
    for (int i = 0; i < int'(VLMAX); i++) begin
      s1[i] = vrf[vs1][i];
      s2[i] = vrf[vs2][i];
      old[i] = vrf[vd][i];
    end
    for (int c = 1; c <= vle + 3; c++) begin
      @(negedge clk);
      exp_rd = (vle > 0) && (c <= vle);
      check_eq("rd_en", 32'(rd_en), 32'(exp_rd));
      if (exp_rd) begin
        check_eq("rd_idx", 32'(rd_idx), 32'(c - 1));
        check_eq("rd_addr1", 32'(rd_addr1), 32'(vs1));
        check_eq("rd_addr2", 32'(rd_addr2), 32'(vs2));
      end
      if (vle > 0 && c >= 2 && c <= vle + 1) begin
        check_eq("alu_mask", 32'(alu_mask), 32'(vm | msk[c - 2]));
        check_eq("alu_operation", 32'(alu_operation), 32'(op));
      end
      exp_wb = 1'b0;
      k = c - 3;
      if (c >= 3 && c <= vle + 2) exp_wb = vm | msk[k];
      check_eq("wb_en", 32'(wb_en), 32'(exp_wb));
      if (exp_wb) begin
        check_eq("wb_idx", 32'(wb_idx), 32'(k));
        check_eq("wb_addr", 32'(wb_addr), 32'(vd));
        check_eq("wb_data", wb_data, alu_ref(op, s2[k], s1[k]));
      end
      exp_done = (vle == 0) ? (c == 1) : (c == vle + 2);
      check_eq("done", 32'(done), 32'(exp_done));
      exp_rdy = (vle == 0) || (c >= vle + 3);
      check_eq("instr_ready", 32'(instr_ready), 32'(exp_rdy));
      if (!hold) begin
        if (noise && c >= 2 && c < vle) begin
          instr_valid = 1'($urandom);
          instr_op = OP_W'($urandom);
          instr_vd = REG_W'($urandom);
          instr_vl = VL_W'($urandom);
        end else begin
          instr_valid = 1'b0;
        end
      end
    end
    for (int i = 0; i < int'(VLMAX); i++) begin
      exp_v = (i < vle && (vm || msk[i])) ? alu_ref(op, s2[i], s1[i]) : old[i];
      check_eq("vd_final", vrf[vd][i], exp_v);
    end
  endtask

  task automatic run(input logic [OP_W-1:0] op, input logic [REG_W-1:0] vd,
                     input logic [REG_W-1:0] vs1, input logic [REG_W-1:0] vs2,
                     input int vl, input logic vm, input bit noise);
    issue(op, vd, vs1, vs2, vl, vm);
    check_instr(op, vd, vs1, vs2, vl, vm, 1'b0, noise);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [OP_W-1:0]  r_op;
    logic [REG_W-1:0] r_vd, r_vs1, r_vs2;
    instr_valid = 1'b0; instr_op = '0; instr_vd = '0; instr_vs1 = '0;
    instr_vs2 = '0; instr_vl = '0; instr_vm = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rd_en", 32'(rd_en), 32'd0);
    check_eq("rst_wb_en", 32'(wb_en), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_alu_mask", 32'(alu_mask), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(instr_ready), 32'd1);
    check_eq("post_rst_wb_data", wb_data, 32'd0);
    check_eq("post_rst_rd_idx", 32'(rd_idx), 32'd0);

    // vadd, unmasked: 11,22,33,44
    for (int i = 0; i < 4; i++) begin
      poke(5'd2, i, 32'(i + 1));
      poke(5'd3, i, 32'(10 * (i + 1)));
    end
    run(4'd0, 5'd4, 5'd3, 5'd2, 4, 1'b1, 1'b0);
    check_eq("vadd_e0", vrf[4][0], 32'd11);
    check_eq("vadd_e3", vrf[4][3], 32'd44);

    // vsub masked by v0 = 0b0101
    v0_bits = 16'h0005;
    run(4'd1, 5'd5, 5'd3, 5'd2, 4, 1'b0, 1'b0);
    check_eq("vsub_e0", vrf[5][0], 32'hFFFF_FFF7);

    // vl = 0 and vl clamped to VLMAX
    run(4'd0, 5'd6, 5'd3, 5'd2, 0, 1'b1, 1'b0);
    run(4'd4, 5'd20, 5'd21, 5'd22, 20, 1'b1, 1'b0);

    // Shift amounts use only the low five bits of the vs1 element
    poke(5'd8, 0, 32'h8000_0000);
    poke(5'd9, 0, 32'h0000_0024);
    run(4'd7, 5'd10, 5'd9, 5'd8, 1, 1'b1, 1'b0);
    check_eq("vsra_result", vrf[10][0], 32'hF800_0000);
    poke(5'd8, 0, 32'h0000_0001);
    poke(5'd9, 0, 32'd33);
    run(4'd5, 5'd11, 5'd9, 5'd8, 1, 1'b1, 1'b0);
    check_eq("vsll_result", vrf[11][0], 32'h0000_0002);

    // Back-to-back with valid held; then valid noise during RUN
    issue(4'd0, 5'd12, 5'd13, 5'd14, 5, 1'b1);
    check_instr(4'd0, 5'd12, 5'd13, 5'd14, 5, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    check_instr(4'd0, 5'd12, 5'd13, 5'd14, 5, 1'b1, 1'b0, 1'b0);
    run(4'd3, 5'd15, 5'd16, 5'd17, 10, 1'b1, 1'b1);

    // Reset in cycle 3 of a vl=8 instruction
    issue(4'd0, 5'd18, 5'd2, 5'd3, 8, 1'b1);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rd_en", 32'(rd_en), 32'd0);
    check_eq("midrst_wb_en", 32'(wb_en), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_alu_mask", 32'(alu_mask), 32'd0);
    check_eq("midrst_rd_idx", 32'(rd_idx), 32'd0);
    check_eq("midrst_wb_data", wb_data, 32'd0);
    check_eq("midrst_wb_addr", 32'(wb_addr), 32'd0);
    check_eq("midrst_alu_op1", alu_op1, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("postrst_wb_en", 32'(wb_en), 32'd0);
      check_eq("postrst_done", 32'(done), 32'd0);
      check_eq("postrst_rd_en", 32'(rd_en), 32'd0);
    end
    run(4'd2, 5'd19, 5'd2, 5'd3, 8, 1'b1, 1'b0);

    // Randomized instructions
    for (int n = 0; n < 25; n++) begin
      r_op  = OP_W'($urandom_range(0, 15));
      r_vd  = REG_W'($urandom_range(1, 31));
      r_vs1 = REG_W'($urandom_range(1, 31));
      r_vs2 = REG_W'($urandom_range(1, 31));
      v0_bits = VLMAX'($urandom);
      run(r_op, r_vd, r_vs1, r_vs2, int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
